// File: rtl/rtc_clock_hms.sv
// Time-of-day counter (24h internal state) with seconds prescaler, run/pause,
// 12h/24h display, range-checked time load and minute-resolution sticky alarm.
module rtc_clock_hms #(
    parameter int DIV       = 100000000,
    parameter bit RESET_24H = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode_24h,
    input  logic       set_valid,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_clr,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       am_pm,
    output logic       sec_tick,
    output logic       day_tick,
    output logic       set_err,
    output logic       alarm_flag
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [4:0]    h24, h24_nxt;
    logic [5:0]    min_nxt, sec_nxt;
    logic [4:0]    hours_nxt;
    logic          pm_nxt;
    logic          stick_nxt, dtick_nxt, serr_nxt;
    logic          tick, set_ok, alarm_hit;

    always_comb begin
        set_ok    = (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);
        tick      = run && (cnt == CNT_MAX);
        cnt_nxt   = cnt;
        h24_nxt   = h24;
        min_nxt   = minutes;
        sec_nxt   = seconds;
        stick_nxt = 1'b0;
        dtick_nxt = 1'b0;
        serr_nxt  = 1'b0;
        alarm_hit = 1'b0;
        hours_nxt = '0;
        pm_nxt    = 1'b0;

        if (run)
            cnt_nxt = tick ? '0 : cnt + 1'b1;

        if (tick) begin
            stick_nxt = 1'b1;
            if (seconds == 6'd59) begin
                sec_nxt = '0;
                if (minutes == 6'd59) begin
                    min_nxt = '0;
                    if (h24 == 5'd23) begin
                        h24_nxt   = '0;
                        dtick_nxt = 1'b1;
                    end else begin
                        h24_nxt = h24 + 5'd1;
                    end
                end else begin
                    min_nxt = minutes + 6'd1;
                end
            end else begin
                sec_nxt = seconds + 6'd1;
            end
        end

        // A valid load overrides a coincident tick entirely, including its pulses.
        if (set_valid && set_ok) begin
            h24_nxt   = set_hour;
            min_nxt   = set_min;
            sec_nxt   = set_sec;
            cnt_nxt   = '0;
            stick_nxt = 1'b0;
            dtick_nxt = 1'b0;
        end else if (set_valid) begin
            serr_nxt = 1'b1;
        end

        // Only a counted second can fire; sec_nxt==0 restricts it to the minute boundary.
        alarm_hit = alarm_en && stick_nxt && (h24_nxt == alarm_hour) &&
                    (min_nxt == alarm_min) && (sec_nxt == 6'd0);

        pm_nxt = (h24_nxt >= 5'd12);
        if (mode_24h)
            hours_nxt = h24_nxt;
        else if (h24_nxt == 5'd0)
            hours_nxt = 5'd12;
        else if (h24_nxt > 5'd12)
            hours_nxt = h24_nxt - 5'd12;
        else
            hours_nxt = h24_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            h24        <= '0;
            minutes    <= '0;
            seconds    <= '0;
            hours      <= RESET_24H ? 5'd0 : 5'd12;
            am_pm      <= 1'b0;
            sec_tick   <= 1'b0;
            day_tick   <= 1'b0;
            set_err    <= 1'b0;
            alarm_flag <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            h24        <= h24_nxt;
            minutes    <= min_nxt;
            seconds    <= sec_nxt;
            hours      <= hours_nxt;
            am_pm      <= pm_nxt;
            sec_tick   <= stick_nxt;
            day_tick   <= dtick_nxt;
            set_err    <= serr_nxt;
            if (alarm_hit)
                alarm_flag <= 1'b1;
            else if (alarm_clr)
                alarm_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rtc_clock_hms.sv
// Directed bench for rtc_clock_hms: DIV=4 and DIV=1 instances (12h reset) plus a
// 24h-reset instance; expectations are queued per step and compared after the edge.
module tb_rtc_clock_hms;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       mode_24h = 1'b0;
    logic       set_valid = 1'b0;
    logic [4:0] set_hour = '0;
    logic [5:0] set_min = '0;
    logic [5:0] set_sec = '0;
    logic       alarm_en = 1'b0;
    logic [4:0] alarm_hour = '0;
    logic [5:0] alarm_min = '0;
    logic       alarm_clr = 1'b0;

    logic [21:0] ov [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [4:0] hours;
        logic [5:0] minutes, seconds;
        logic       am_pm, sec_tick, day_tick, set_err, alarm_flag;

        rtc_clock_hms #(
            .DIV       ((g == 0) ? 4 : 1),
            .RESET_24H (g == 2)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .run        (run),
            .mode_24h   (mode_24h),
            .set_valid  (set_valid),
            .set_hour   (set_hour),
            .set_min    (set_min),
            .set_sec    (set_sec),
            .alarm_en   (alarm_en),
            .alarm_hour (alarm_hour),
            .alarm_min  (alarm_min),
            .alarm_clr  (alarm_clr),
            .hours      (hours),
            .minutes    (minutes),
            .seconds    (seconds),
            .am_pm      (am_pm),
            .sec_tick   (sec_tick),
            .day_tick   (day_tick),
            .set_err    (set_err),
            .alarm_flag (alarm_flag)
        );

        assign ov[g] = {hours, minutes, seconds, am_pm, sec_tick, day_tick, set_err, alarm_flag};
    end

    typedef struct {
        string       tag;
        int          sel;
        logic [21:0] v;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic push(input string tag, input int sel, input int h, input int m, input int s,
                        input bit pm, input bit st, input bit dt, input bit se, input bit af);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.v   = {5'(h), 6'(m), 6'(s), pm, st, dt, se, af};
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            assert (ov[e.sel] === e.v) else begin
                n_mis++;
                $error("FAIL %s dut%0d: got %0d:%0d:%0d pm/st/dt/se/af=%b, want %0d:%0d:%0d pm/st/dt/se/af=%b",
                       e.tag, e.sel, ov[e.sel][21:17], ov[e.sel][16:11], ov[e.sel][10:5], ov[e.sel][4:0],
                       e.v[21:17], e.v[16:11], e.v[10:5], e.v[4:0]);
            end
        end
    endtask

    task automatic step(input string tag, input int sel, input int h, input int m, input int s,
                        input bit pm, input bit st, input bit dt, input bit se, input bit af);
        push(tag, sel, h, m, s, pm, st, dt, se, af);
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic load(input int h, input int m, input int s);
        set_valid = 1'b1;
        set_hour  = 5'(h);
        set_min   = 6'(m);
        set_sec   = 6'(s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset: visible before any clock edge.
        #2 rst = 1'b1;
        #1;
        push("rst12_div4", 0, 12, 0, 0, 0, 0, 0, 0, 0);
        push("rst12_div1", 1, 12, 0, 0, 0, 0, 0, 0, 0);
        push("rst24",      2,  0, 0, 0, 0, 0, 0, 0, 0);
        drain();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;

        // DIV=4 prescaler: one second every four edges, starting from cnt=0.
        for (int k = 1; k <= 12; k++)
            step("run_div4", 0, 12, 0, k / 4, 0, (k % 4) == 0, 0, 0, 0);

        // 12h AM/PM transitions on DIV=1 (every load also coincides with a tick).
        load(11, 59, 58);
        step("ld_115958", 1, 11, 59, 58, 0, 0, 0, 0, 0);
        set_valid = 1'b0;
        step("am_115959", 1, 11, 59, 59, 0, 1, 0, 0, 0);
        step("pm_1200",   1, 12,  0,  0, 1, 1, 0, 0, 0);
        load(12, 59, 58);
        step("ld_125958", 1, 12, 59, 58, 1, 0, 0, 0, 0);
        set_valid = 1'b0;
        step("pm_125959", 1, 12, 59, 59, 1, 1, 0, 0, 0);
        step("pm_0100",   1,  1,  0,  0, 1, 1, 0, 0, 0);

        // Day rollover in 24h mode, then re-encode in 12h mode.
        mode_24h = 1'b1;
        load(23, 59, 59);
        step("ld_235959", 1, 23, 59, 59, 1, 0, 0, 0, 0);
        set_valid = 1'b0;
        step("day_wrap",  1,  0,  0,  0, 0, 1, 1, 0, 0);
        step("after_day", 1,  0,  0,  1, 0, 1, 0, 0, 0);
        mode_24h = 1'b0;
        step("mode_12h",  1, 12,  0,  2, 0, 1, 0, 0, 0);

        // Rejected loads: time keeps ticking, set_err pulses.
        load(5, 60, 0);
        step("bad_min",  1, 12, 0, 3, 0, 1, 0, 1, 0);
        load(24, 0, 0);
        step("bad_hour", 1, 12, 0, 4, 0, 1, 0, 1, 0);
        set_valid = 1'b0;
        step("err_gone", 1, 12, 0, 5, 0, 1, 0, 0, 0);

        // Alarm at 07:30.
        alarm_en   = 1'b1;
        alarm_hour = 5'd7;
        alarm_min  = 6'd30;
        load(7, 29, 59);
        step("ld_072959", 1, 7, 29, 59, 0, 0, 0, 0, 0);
        set_valid = 1'b0;
        step("alarm_fire", 1, 7, 30, 0, 0, 1, 0, 0, 1);
        for (int i = 1; i <= 5; i++)
            step("alarm_hold", 1, 7, 30, i, 0, 1, 0, 0, 1);
        alarm_clr = 1'b1;
        step("alarm_clr", 1, 7, 30, 6, 0, 1, 0, 0, 0);
        alarm_clr = 1'b0;
        load(7, 30, 0);
        step("ld_073000", 1, 7, 30, 0, 0, 0, 0, 0, 0);
        set_valid = 1'b0;
        step("no_fire",   1, 7, 30, 1, 0, 1, 0, 0, 0);
        load(7, 29, 59);
        step("ld_again",  1, 7, 29, 59, 0, 0, 0, 0, 0);
        set_valid = 1'b0;
        alarm_clr = 1'b1;
        step("fire_vs_clr", 1, 7, 30, 0, 0, 1, 0, 0, 1);
        alarm_clr = 1'b0;
        step("fire_kept",   1, 7, 30, 1, 0, 1, 0, 0, 1);
        alarm_en  = 1'b0;
        alarm_clr = 1'b1;

        // Pause on DIV=4 with cnt=2.
        load(0, 0, 0);
        step("ld4_0000", 0, 12, 0, 0, 0, 0, 0, 0, 0);
        set_valid = 1'b0;
        alarm_clr = 1'b0;
        step("cnt1", 0, 12, 0, 0, 0, 0, 0, 0, 0);
        step("cnt2", 0, 12, 0, 0, 0, 0, 0, 0, 0);
        run = 1'b0;
        for (int i = 0; i < 10; i++)
            step("paused", 0, 12, 0, 0, 0, 0, 0, 0, 0);
        run = 1'b1;
        step("resume_cnt3", 0, 12, 0, 0, 0, 0, 0, 0, 0);
        step("resume_tick", 0, 12, 0, 1, 0, 1, 0, 0, 0);
        step("post_tick",   0, 12, 0, 1, 0, 0, 0, 0, 0);

        // Reset asserted mid-cycle during a pending load.
        load(5, 5, 5);
        #3 rst = 1'b1;
        #1;
        push("midrst_div4", 0, 12, 0, 0, 0, 0, 0, 0, 0);
        push("midrst_div1", 1, 12, 0, 0, 0, 0, 0, 0, 0);
        drain();
        set_valid = 1'b0;
        #1 rst = 1'b0;
        for (int k = 1; k <= 3; k++)
            step("rst_cnt", 0, 12, 0, 0, 0, 0, 0, 0, 0);
        step("rst_tick", 0, 12, 0, 1, 0, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
